mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage (read-only) and the data-memory stage (read/write) of the pipelined RISC core.
- Serialises requests with a small FSM and returns one-cycle acks that the pipeline uses to stall or advance.
- Sits inside top, between IF/MEM stage logic and the memory macro.
- Fixed-latency memory model; one transaction in flight at a time.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held until if_ack.
- if_addr  input  AW  fetch address; stable while if_req is high.
- if_rdata  output  DW  fetched word; valid in the if_ack cycle, held until the next if_ack.
- if_ack  output  1  one-cycle completion pulse.
- dm_req  input  1  data request; held until dm_ack.
- dm_we  input  1  1 = write, 0 = read.
- dm_addr  input  AW  data address.
- dm_wdata  input  DW  write data.
- dm_rdata  output  DW  read data; valid in the dm_ack cycle, held until the next read dm_ack.
- dm_ack  output  1  one-cycle completion pulse.
- mem_en  output  1  memory access strobe, exactly one cycle per transaction.
- mem_we  output  1  write enable, qualified by mem_en.
- mem_addr  output  AW  memory address (registered).
- mem_wdata  output  DW  memory write data (registered).
- mem_rdata  input  DW  memory read data, valid LAT cycles after the mem_en cycle.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state = IDLE. if_ack, dm_ack, mem_en, mem_we and busy = 0. if_rdata, dm_rdata, mem_addr, mem_wdata and owner = 0. Latency counter = 0.
- Reset asserted mid-transaction aborts it; no ack is issued for that transaction.
- State IDLE:
  - If no request is high, remain in IDLE.
  - If a request is high, pick a winner per the priority rule and latch owner, addr, we and wdata into the mem_* registers. Next state is ISSUE.
- State ISSUE:
  - mem_en = 1 and mem_we = latched we for exactly this cycle.
  - Counter loaded with LAT. Next state is WAIT.
- State WAIT:
  - Counter decrements each cycle.
  - When counter == 1, capture mem_rdata into the owner's rdata register, for reads only. Next state is ACK.
- State ACK:
  - Owner's ack = 1 for this cycle only. Next state is IDLE.
- Timing: a request sampled in IDLE at cycle s gives ISSUE at s+1, mem_rdata valid at s+1+LAT, and ack at s+LAT+2.
  - Back-to-back throughput: one transaction per LAT+3 cycles.
- Requester protocol:
  - The requester updates req/addr on the edge that ends its ack cycle.
  - The IDLE cycle following ACK therefore always sees fresh inputs; there are no duplicate grants.
- Writes: same timing as reads. dm_rdata is unchanged by a write; the ack is still pulsed.
- If req drops mid-transaction, the transaction still completes and the ack still fires. Request inputs are ignored outside IDLE.
- Priority (default): dm_req beats if_req on simultaneous requests. This clears the older MEM-stage instruction first and avoids pipeline deadlock.
- if_ack and dm_ack are never high in the same cycle. mem_en is never high outside ISSUE.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_grant flop (reset value = IF) records the last winner.
  - On simultaneous requests, the requester not granted last wins.
  - Single requests are granted immediately regardless of last_grant.
- Undefined: fixed dm-over-if priority; no last_grant flop is present.

Test Plan:
- Reset: hold rst for 3 cycles mid-WAIT. Required: all outputs 0, no ack, busy = 0 the cycle after reset is released.
- Single fetch, LAT = 2: if_req with if_addr = 0x10 sampled at cycle s; memory returns 0xDEADBEEF at s+3. Required: mem_en only at s+1 with mem_addr = 0x10; if_ack at s+4 with if_rdata = 0xDEADBEEF.
- Data write then read: dm write addr 0x40, data 0x12345678, then dm read addr 0x40. Required: mem_we = 1 with mem_wdata = 0x12345678 on the first ISSUE; the read's dm_ack shows dm_rdata = 0x12345678; dm_rdata is unchanged after the write ack.
- Simultaneous if_req and dm_req held high, without ARB_RR_EN. Required: dm granted first, if granted next, if_ack LAT+3 cycles after dm_ack.
- Same stimulus with ARB_RR_EN, both held for 4 transactions. Required: grant order dm, if, dm, if (last_grant resets to IF).
- LAT = 1 boundary, continuous if_req with incrementing addresses 0, 4, 8. Required: an ack every 4 cycles, correct data each time, busy low for exactly one cycle between transactions.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF fetches and MEM-stage loads/stores (ARB_RR_EN = round-robin, else dm wins).
// Latency: ack LAT+2 cycles after the request is sampled in IDLE; one transaction per LAT+3 cycles, one in flight.
// Backpressure: requesters hold req until their one-cycle ack; request inputs are ignored while busy.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t     state;
  state_t     state_nxt;
  logic       owner_dm;
  logic       we_q;
  logic [3:0] cnt;
  logic       req_any;
  logic       grant_dm;
  logic       prio_dm;

  assign req_any  = if_req | dm_req;
  assign grant_dm = dm_req & (~if_req | prio_dm);

`ifdef ARB_RR_EN
  // On a tie, whoever was not served last goes first; resets as if IF was served last.
  logic last_dm;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dm <= 1'b0;
    end else if (state == ST_IDLE && req_any) begin
      last_dm <= grant_dm;
    end
  end

  assign prio_dm = ~last_dm;
`else
  // MEM stage holds the older instruction, so it must win to avoid deadlock.
  assign prio_dm = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_any) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == 4'd1) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state == ST_ISSUE);
    mem_we = (state == ST_ISSUE) & we_q;
    if_ack = (state == ST_ACK) & ~owner_dm;
    dm_ack = (state == ST_ACK) & owner_dm;
    busy   = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_dm  <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            owner_dm  <= grant_dm;
            we_q      <= grant_dm & dm_we;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            mem_wdata <= grant_dm ? dm_wdata : '0;
          end
        end
        ST_ISSUE: cnt <= LAT_CNT;
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          // Last wait cycle is exactly when the macro presents read data.
          if (cnt == 4'd1 && !we_q) begin
            if (owner_dm) begin
              dm_rdata <= mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
